// File: rtl/move_scheduler.sv
// move_scheduler: turns one-cycle move pulses and the gravity tick into
// pending requests and issues them one at a time to the game engine over a
// valid/ready handshake.
// Issue order: DROP, promoted GRAVITY, ROTATE, LEFT/RIGHT, DOWN, GRAVITY.
// A left pulse cancels a pending right and vice versa; a drop cancels any
// pending lateral, down or gravity request.
// All requests are flushed while the engine locks or spawns a piece, and for
// LOCK_SETTLE cycles after the lock ends.
// Optional build macro MOVE_SCHED_STATS_EN adds two counters:
//   merged_cnt  - pulses absorbed into a pending request, plus left/right cancels
//   discard_cnt - pulses ignored during lock/settle, plus requests flushed
//                 when a lock begins
module move_scheduler #(
  parameter int unsigned LOCK_SETTLE  = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_left,
  input  logic       pulse_right,
  input  logic       pulse_rotate,
  input  logic       pulse_down,
  input  logic       pulse_drop,
  input  logic       gravity_tick,
  input  logic       engine_lock,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code
`ifdef MOVE_SCHED_STATS_EN
  ,
  output logic [7:0] merged_cnt,
  output logic [7:0] discard_cnt
`endif
);

  // Pending bit k-1 holds command code k.
  localparam int unsigned SW = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOCK, S_SETTLE} state_t;

  state_t          state_q;
  logic [5:0]      pend_q, pend_d;
  logic [7:0]      starve_q, starve_d;
  logic [SW-1:0]   settle_q;
  logic            cmd_valid_q;
  logic [2:0]      cmd_code_q;

  logic [5:0]      pulses, pend_eff, clr, set;
  logic            hs, live, lock_entry, promoted;
  logic [2:0]      next_code;

  assign pulses     = {gravity_tick, pulse_drop, pulse_down, pulse_rotate, pulse_right, pulse_left};
  assign hs         = (state_q == S_ISSUE) && cmd_ready;
  assign lock_entry = engine_lock && ((state_q == S_IDLE) || (state_q == S_ISSUE));
  assign live       = ((state_q == S_IDLE) || (state_q == S_ISSUE)) && !engine_lock;
  assign promoted   = (starve_q >= 8'(STARVE_LIMIT));
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;

  // Pending update: the handshake clears the issued bit, cancels are applied
  // next, and fresh pulses are applied last so a same-kind pulse re-arms.
  always_comb begin
    pend_eff = pend_q;
    if (hs) pend_eff[cmd_code_q - 3'd1] = 1'b0;
    clr = '0;
    set = pulses;
    if (pulse_left)  clr[1] = 1'b1;
    if (pulse_right) clr[0] = 1'b1;
    if (pulse_drop)  clr = clr | 6'b101011;
    if (pulse_left && pulse_right) set[1:0] = 2'b00;
    pend_d = live ? ((pend_eff & ~clr) | set) : '0;
  end

  // Gravity anti-starvation counter; it is cleared by a lock flush.
  always_comb begin
    starve_d = starve_q;
    if (!live || (hs && cmd_code_q == 3'd6) || !pend_q[5])
      starve_d = '0;
    else if (hs && starve_q != 8'hFF)
      starve_d = starve_q + 8'd1;
  end

  // Highest-priority pending code; 0 means nothing is pending.
  always_comb begin
    next_code = 3'd0;
    if      (pend_q[4])             next_code = 3'd5;
    else if (pend_q[5] && promoted) next_code = 3'd6;
    else if (pend_q[2])             next_code = 3'd3;
    else if (pend_q[0])             next_code = 3'd1;
    else if (pend_q[1])             next_code = 3'd2;
    else if (pend_q[3])             next_code = 3'd4;
    else if (pend_q[5])             next_code = 3'd6;
  end

  // Pending and starve state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      starve_q <= '0;
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end

  // Scheduler FSM with registered command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 3'd0;
      settle_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (engine_lock) begin
            state_q <= S_LOCK;
          end else if (next_code != 3'd0) begin
            state_q     <= S_ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= next_code;
          end
        end
        S_ISSUE: begin
          // A lock withdraws the command; a handshake in the same cycle
          // still counts on the engine side.
          if (engine_lock || cmd_ready) begin
            state_q     <= engine_lock ? S_LOCK : S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 3'd0;
          end
        end
        S_LOCK: begin
          if (!engine_lock) begin
            if (LOCK_SETTLE == 0) begin
              state_q <= S_IDLE;
            end else begin
              state_q  <= S_SETTLE;
              settle_q <= SW'(LOCK_SETTLE);
            end
          end
        end
        S_SETTLE: begin
          if (engine_lock) begin
            state_q <= S_LOCK;
          end else if (settle_q <= SW'(1)) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
          cmd_code_q  <= 3'd0;
        end
      endcase
    end
  end

`ifdef MOVE_SCHED_STATS_EN
  function automatic logic [3:0] popcnt6(input logic [5:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [3:0] inc);
    logic [8:0] s;
    s = {1'b0, c} + {5'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [7:0] merged_q, discard_q;
  logic [3:0] merge_inc, discard_inc;

  // Per-cycle increments for the statistics counters.
  always_comb begin
    merge_inc   = '0;
    discard_inc = '0;
    if (live)
      merge_inc = popcnt6(pulses & pend_eff)
                + 4'(pulse_left  & pend_eff[1])
                + 4'(pulse_right & pend_eff[0])
                + 4'(pulse_left  & pulse_right);
    else if (lock_entry)
      discard_inc = popcnt6(pend_eff) + popcnt6(pulses);
    else
      discard_inc = popcnt6(pulses);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      merged_q  <= '0;
      discard_q <= '0;
    end else begin
      merged_q  <= sat_add(merged_q, merge_inc);
      discard_q <= sat_add(discard_q, discard_inc);
    end
  end

  assign merged_cnt  = merged_q;
  assign discard_cnt = discard_q;
`endif

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed test-plan scenarios, then
// random traffic, all compared every cycle against a behavioural model.
module tb_move_scheduler;
  localparam int LS = 4;
  localparam int SL = 2;

  logic clk = 1'b0;
  logic rst, pulse_left, pulse_right, pulse_rotate, pulse_down, pulse_drop, gravity_tick;
  logic engine_lock, cmd_ready, cmd_valid;
  logic [2:0] cmd_code;
`ifdef MOVE_SCHED_STATS_EN
  logic [7:0] merged_cnt, discard_cnt;
`endif

  move_scheduler #(.LOCK_SETTLE(LS), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .pulse_left(pulse_left), .pulse_right(pulse_right), .pulse_rotate(pulse_rotate),
    .pulse_down(pulse_down), .pulse_drop(pulse_drop), .gravity_tick(gravity_tick),
    .engine_lock(engine_lock), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code)
`ifdef MOVE_SCHED_STATS_EN
    , .merged_cnt(merged_cnt), .discard_cnt(discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int issued_sig;   // handshaken codes as decimal digits, oldest first

  // Reference model. Modes: 0 idle, 1 offering a command, 2 locked, 3 settling.
  int       m_mode, m_cur, m_starve, m_settle;
  bit [6:1] m_pend;

  function automatic int best_code();
    if (m_pend[5]) return 5;
    if (m_pend[6] && m_starve >= SL) return 6;
    if (m_pend[3]) return 3;
    if (m_pend[1]) return 1;
    if (m_pend[2]) return 2;
    if (m_pend[4]) return 4;
    if (m_pend[6]) return 6;
    return 0;
  endfunction

  task automatic model_edge(input logic [5:0] p, input logic rdy, input logic lk, input logic rs);
    bit [6:1] np;
    bit hs, live;
    int nb;
    if (rs) begin
      m_mode = 0; m_cur = 0; m_starve = 0; m_settle = 0; m_pend = '0;
      return;
    end
    hs   = (m_mode == 1) && rdy;
    live = (m_mode <= 1) && !lk;
    nb   = best_code();
    np   = m_pend;
    if (!live) np = '0;
    else begin
      if (hs) np[m_cur] = 1'b0;
      if (p[0]) np[2] = 1'b0;
      if (p[1]) np[1] = 1'b0;
      if (p[4]) begin np[1] = 0; np[2] = 0; np[4] = 0; np[6] = 0; end
      for (int k = 1; k <= 6; k++)
        if (p[k-1] && !(k <= 2 && p[0] && p[1])) np[k] = 1'b1;
    end
    if (!live || (hs && m_cur == 6) || !m_pend[6]) m_starve = 0;
    else if (hs && m_starve < 255) m_starve++;
    case (m_mode)
      0: if (lk) m_mode = 2; else if (nb != 0) begin m_mode = 1; m_cur = nb; end
      1: if (lk) m_mode = 2; else if (rdy) m_mode = 0;
      2: if (!lk) begin
           if (LS == 0) m_mode = 0; else begin m_mode = 3; m_settle = LS; end
         end
      default: if (lk) m_mode = 2;
               else if (m_settle <= 1) begin m_mode = 0; m_settle = 0; end
               else m_settle--;
    endcase
    m_pend = np;
  endtask

  // One clock: drive, log handshakes, step model at the edge, check at edge+1.
  task automatic cyc(input logic [5:0] p, input logic rdy = 1'b1,
                     input logic lk = 1'b0, input logic rs = 1'b0);
    logic       ev;
    logic [2:0] ec;
    {gravity_tick, pulse_drop, pulse_down, pulse_rotate, pulse_right, pulse_left} = p;
    cmd_ready = rdy; engine_lock = lk; rst = rs;
    if (cmd_valid === 1'b1 && rdy && !rs) issued_sig = issued_sig * 10 + int'(cmd_code);
    @(posedge clk);
    model_edge(p, rdy, lk, rs);
    #1;
    ev = (m_mode == 1);
    ec = ev ? 3'(m_cur) : 3'd0;
    n_vec++;
    assert (cmd_valid === ev) else begin
      n_err++; $error("FAIL cmd_valid t=%0t got %b exp %b", $time, cmd_valid, ev);
    end
    n_vec++;
    assert (cmd_code === ec) else begin
      n_err++; $error("FAIL cmd_code t=%0t got %0d exp %0d", $time, cmd_code, ec);
    end
  endtask

  task automatic idle(input int n, input logic rdy = 1'b1);
    for (int i = 0; i < n; i++) cyc(6'b0, rdy);
  endtask

  task automatic chk_seq(input string tag, input int exp);
    n_vec++;
    assert (issued_sig === exp) else begin
      n_err++; $error("FAIL %s got %0d exp %0d", tag, issued_sig, exp);
    end
    issued_sig = 0;
  endtask

  // pulse bit positions: 0 left, 1 right, 2 rotate, 3 down, 4 drop, 5 gravity
  localparam logic [5:0] P_L = 6'b000001, P_R = 6'b000010, P_ROT = 6'b000100;
  localparam logic [5:0] P_DN = 6'b001000, P_DR = 6'b010000, P_G = 6'b100000;

  initial begin
    logic       lk;
    logic [5:0] p;
    issued_sig = 0;
    cyc(6'b0, 1'b1, 1'b0, 1'b1);
    cyc(6'b0, 1'b1, 1'b0, 1'b1);
    idle(8);

    // single pulse: valid for exactly one cycle with code 1
    cyc(P_L); idle(4);
    chk_seq("single_left", 1);

    // simultaneous rotate/down/gravity issue in priority order
    cyc(P_ROT | P_DN | P_G); idle(8);
    chk_seq("simultaneous", 346);

    // left+right same cycle cancel each other
    cyc(P_L | P_R); idle(4);
    chk_seq("lr_cancel", 0);

    // stalled right held until ready
    cyc(P_R, 1'b0); idle(6, 1'b0); idle(3);
    chk_seq("stall_right", 2);

    // drop flushes pending left while rotate is stalled
    cyc(P_ROT, 1'b0); cyc(P_L, 1'b0); cyc(P_DR, 1'b0); idle(8);
    chk_seq("drop_flush", 35);

    // gravity promoted after SL rotate handshakes
    cyc(P_G | P_ROT); cyc(0); cyc(P_ROT); cyc(0); cyc(P_ROT); cyc(0); cyc(P_ROT); idle(6);
    chk_seq("starvation", 3363);

    // lock during a stalled issue; pulses in lock and settle are dropped
    cyc(P_L, 1'b0); cyc(0, 1'b0); cyc(0, 1'b0, 1'b1);
    cyc(P_R, 1'b1, 1'b1); cyc(P_DR, 1'b1, 1'b1); cyc(P_G, 1'b1, 1'b1);
    cyc(P_ROT, 1'b1, 1'b0);
    cyc(P_DN); cyc(P_L); cyc(P_R); cyc(P_G);
    idle(3);
    chk_seq("lock_discard", 0);
    cyc(P_L); idle(3);
    chk_seq("after_lock", 1);

    // reset while a command is offered
    cyc(P_DN, 1'b0); cyc(P_ROT, 1'b0); cyc(P_R, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk_seq("reset_issue", 0);
`ifdef MOVE_SCHED_STATS_EN
    cyc(0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    assert (merged_cnt === 8'd0 && discard_cnt === 8'd0) else begin
      n_err++; $error("FAIL stats_reset got %0d/%0d exp 0/0", merged_cnt, discard_cnt);
    end
`endif

    // random traffic against the model
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      p = '0;
      for (int b = 0; b < 6; b++) p[b] = ($urandom_range(0, 6) == 0);
      if (lk) lk = ($urandom_range(0, 5) != 0);
      else    lk = ($urandom_range(0, 40) == 0);
      cyc(p, ($urandom_range(0, 3) != 0), lk, ($urandom_range(0, 400) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Collects single-cycle move pulses from the per-key auto-repeat handlers plus the gravity tick, and holds each as a pending request.
- Issues one command at a time to the game engine over a valid/ready handshake, using fixed priority, left/right conflict cancel, and gravity anti-starvation.
- Flushes all requests while the engine locks or spawns a piece.

Parameters:
- LOCK_SETTLE, 4: cycles after engine_lock falls during which input pulses are ignored; 0 means go straight to IDLE.
- STARVE_LIMIT, 8: number of commands issued while gravity is pending before gravity is promoted; range 1..255.

Ports:
- clk in 1: system clock.
- rst in 1: reset; synchronous, active-high.
- pulse_left in 1: one-cycle request from the left-key handler.
- pulse_right in 1: one-cycle request from the right-key handler.
- pulse_rotate in 1: one-cycle request from the rotate-key handler.
- pulse_down in 1: one-cycle soft-drop request.
- pulse_drop in 1: one-cycle hard-drop request.
- gravity_tick in 1: one-cycle gravity request from the fall timer.
- engine_lock in 1: high while the engine locks, clears lines or spawns.
- cmd_valid out 1: command available.
- cmd_code out 3: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DOWN, 5 DROP, 6 GRAVITY; 0 when idle.
- cmd_ready in 1: engine accepts the command; handshake occurs when cmd_valid and cmd_ready are both high.

Behaviour:
- Reset: state IDLE; all pending bits 0; cmd_valid 0; cmd_code 0; starve counter 0.
- Pending set/clear, one bit per code:
  - A pulse sets its bit.
  - A pulse on a bit that is already pending merges; it does not queue a second command.
  - pulse_left clears pending RIGHT, and pulse_right clears pending LEFT.
  - pulse_left and pulse_right in the same cycle: both bits end up cleared.
  - pulse_drop clears pending LEFT, RIGHT, DOWN and GRAVITY; ROTATE is kept.
  - The issued bit is cleared on handshake. A same-kind pulse in the handshake cycle wins and re-sets the bit.
- Priority, highest first:
  - DROP.
  - GRAVITY, only if promoted (starve counter >= STARVE_LIMIT).
  - ROTATE.
  - LEFT or RIGHT (mutually exclusive by construction).
  - DOWN.
  - GRAVITY.
- Starve counter:
  - Increments, saturating, on each handshake of a non-GRAVITY code while GRAVITY is pending.
  - Clears on a GRAVITY handshake, or when GRAVITY is not pending.
- FSM states: IDLE, ISSUE, LOCK, SETTLE.
  - IDLE: if any bit is pending, latch the highest-priority code and go to ISSUE. cmd_valid=1 and cmd_code are registered outputs.
  - Latency: a pulse sampled at edge N gives cmd_valid high after edge N+1.
  - ISSUE: cmd_code stays stable and cmd_valid stays held until handshake. After handshake go to IDLE with cmd_valid=0, cmd_code=0.
  - Maximum throughput is therefore one command per 2 cycles.
- Lock handling:
  - engine_lock high in IDLE or ISSUE: go to LOCK and clear all pending bits and the starve counter.
  - If cmd_ready is also high in that ISSUE cycle, the handshake counts; otherwise cmd_valid is withdrawn. This is the only legal withdrawal.
  - In LOCK, pulses are discarded.
  - When engine_lock falls, go to SETTLE and load LOCK_SETTLE.
  - SETTLE: pulses are discarded and the counter decrements; at 0 go to IDLE.
  - engine_lock rising again during SETTLE returns to LOCK.
- rst mid-operation: reset values are restored on the next edge regardless of state; cmd_valid drops with no handshake.
- Outputs are registered; there is no combinational path from the inputs to cmd_valid.

Optional Feature:
- Macro: MOVE_SCHED_STATS_EN.
- Defined: adds the following output ports. Both counters are cleared by rst.
  - merged_cnt out 8: saturating count of pulses that hit an already-pending bit, plus left/right cancels.
  - discard_cnt out 8: saturating count of pulses ignored in LOCK or SETTLE, plus bits flushed on lock entry.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single pulse:
  - Stimulus: pulse_left at cycle 10, cmd_ready tied 1.
  - Required: cmd_valid=1, cmd_code=1 in cycle 12 only, then IDLE with cmd_code=0.
- Simultaneous requests:
  - Stimulus: pulse_rotate, pulse_down and gravity_tick all in one cycle, cmd_ready=1.
  - Required: codes issued in order 3, 4, 6, two cycles apart.
- Conflict cancel, stall and drop flush:
  - pulse_left and pulse_right in the same cycle -> no command.
  - pulse_right with cmd_ready=0 for 5 cycles -> cmd_code=2 held stable, then handshake on ready.
  - pulse_drop with LEFT pending -> only code 5 issued.
- Starvation:
  - Stimulus: STARVE_LIMIT=2; gravity pending while rotate pulses arrive every 2 cycles.
  - Required: after 2 ROTATE handshakes, GRAVITY (6) issues before the next ROTATE.
- Lock:
  - Stimulus: engine_lock during ISSUE with cmd_ready=0; pulses during LOCK and the 4 SETTLE cycles; then pulse_left.
  - Required: cmd_valid drops; none of those pulses produce a command; the later pulse_left issues code 1.
- Reset during ISSUE:
  - Required: cmd_valid=0 and pending=0 next cycle; with MOVE_SCHED_STATS_EN, merged_cnt and discard_cnt read 0.
